// File: rtl/alu_pkg.sv
// Shared types and encodings for the ALU issue path: unit/sub-op enums,
// MIPS opcode/funct values, operand-select codes and the issued bundle.
package alu_pkg;

  // Width of the operand fields carried in issue_bundle_t.
  localparam int ALU_DATA_W = 32;

  typedef enum logic [1:0] {
    UNIT_LOGIC = 2'b00,
    UNIT_ARITH = 2'b01,
    UNIT_SHIFT = 2'b10,
    UNIT_RSVD  = 2'b11
  } alu_unit_e;

  typedef enum logic [1:0] {
    LOP_AND = 2'b00,
    LOP_OR  = 2'b01,
    LOP_XOR = 2'b10,
    LOP_NOR = 2'b11
  } logic_op_e;

  typedef enum logic [1:0] {
    AOP_ADD  = 2'b00,
    AOP_SUB  = 2'b01,
    AOP_SLT  = 2'b10,
    AOP_SLTU = 2'b11
  } arith_op_e;

  typedef enum logic [1:0] {
    SOP_SLL  = 2'b00,
    SOP_SRL  = 2'b01,
    SOP_SRA  = 2'b10,
    SOP_RSVD = 2'b11
  } shift_op_e;

  // Operand A / B source selects produced by the decoder.
  typedef enum logic [1:0] {
    ASEL_ZERO = 2'b00,
    ASEL_RS   = 2'b01,
    ASEL_RT   = 2'b10
  } a_sel_e;

  typedef enum logic [2:0] {
    BSEL_ZERO  = 3'd0,
    BSEL_RT    = 3'd1,
    BSEL_ZIMM  = 3'd2,
    BSEL_SIMM  = 3'd3,
    BSEL_SHAMT = 3'd4,
    BSEL_LUI   = 3'd5
  } b_sel_e;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
    alu_unit_e             unit;
    logic [1:0]            op;
    logic                  illegal;
  } issue_bundle_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational decode of opcode/funct into ALU unit, sub-op and
// operand-source selects. Non-ALU encodings come out as illegal with all
// selects forced to zero.
module alu_ctrl_decode
  import alu_pkg::*;
#(
  parameter bit EN_SHIFT = 1'b1
) (
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output alu_unit_e  o_unit,
  output logic [1:0] o_op,
  output a_sel_e     o_a_sel,
  output b_sel_e     o_b_sel,
  output logic       o_illegal
);

  logic w_legal;
  logic w_is_shift;

  // Opcode/funct decode; an illegal result overrides everything at the end.
  always_comb begin
    o_unit     = UNIT_LOGIC;
    o_op       = 2'b00;
    o_a_sel    = ASEL_RS;
    o_b_sel    = BSEL_RT;
    w_legal    = 1'b1;
    w_is_shift = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_SLL:          begin o_unit = UNIT_SHIFT; o_op = SOP_SLL;  w_is_shift = 1'b1; end
          FN_SRL:          begin o_unit = UNIT_SHIFT; o_op = SOP_SRL;  w_is_shift = 1'b1; end
          FN_SRA:          begin o_unit = UNIT_SHIFT; o_op = SOP_SRA;  w_is_shift = 1'b1; end
          FN_ADD, FN_ADDU: begin o_unit = UNIT_ARITH; o_op = AOP_ADD;  end
          FN_SUB, FN_SUBU: begin o_unit = UNIT_ARITH; o_op = AOP_SUB;  end
          FN_SLT:          begin o_unit = UNIT_ARITH; o_op = AOP_SLT;  end
          FN_SLTU:         begin o_unit = UNIT_ARITH; o_op = AOP_SLTU; end
          FN_AND:          o_op = LOP_AND;
          FN_OR:           o_op = LOP_OR;
          FN_XOR:          o_op = LOP_XOR;
          FN_NOR:          o_op = LOP_NOR;
          default:         w_legal = 1'b0;
        endcase
        // Shifts take the value from rt and the amount from shamt.
        if (w_is_shift) begin
          o_a_sel = ASEL_RT;
          o_b_sel = BSEL_SHAMT;
          w_legal = EN_SHIFT;
        end
      end
      OP_ADDI, OP_ADDIU: begin o_unit = UNIT_ARITH; o_op = AOP_ADD;  o_b_sel = BSEL_SIMM; end
      OP_SLTI:           begin o_unit = UNIT_ARITH; o_op = AOP_SLT;  o_b_sel = BSEL_SIMM; end
      OP_SLTIU:          begin o_unit = UNIT_ARITH; o_op = AOP_SLTU; o_b_sel = BSEL_SIMM; end
      OP_ANDI:           begin o_op = LOP_AND; o_b_sel = BSEL_ZIMM; end
      OP_ORI:            begin o_op = LOP_OR;  o_b_sel = BSEL_ZIMM; end
      OP_XORI:           begin o_op = LOP_XOR; o_b_sel = BSEL_ZIMM; end
      // LUI is issued as 0 | (imm << 16) on the logic unit.
      OP_LUI:            begin o_op = LOP_OR; o_a_sel = ASEL_ZERO; o_b_sel = BSEL_LUI; end
      default:           w_legal = 1'b0;
    endcase
    if (!w_legal) begin
      o_unit  = UNIT_LOGIC;
      o_op    = 2'b00;
      o_a_sel = ASEL_ZERO;
      o_b_sel = BSEL_ZERO;
    end
  end

  assign o_illegal = !w_legal;

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes the incoming instruction, builds operands A/B and
// queues the resulting bundle in a 2-entry FIFO skid buffer toward execute.
// DATA_W must not exceed alu_pkg::ALU_DATA_W (the bundle field width).
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W   = ALU_DATA_W,
  parameter bit EN_SHIFT = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [31:0]       i_instr,
  input  logic [DATA_W-1:0] i_rs_val,
  input  logic [DATA_W-1:0] i_rt_val,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  output logic [1:0]        o_alu_unit,
  output logic [1:0]        o_alu_op,
  output logic              o_illegal
);

  alu_unit_e     w_unit;
  logic [1:0]    w_op;
  a_sel_e        w_a_sel;
  b_sel_e        w_b_sel;
  logic          w_illegal;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  issue_bundle_t w_new;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_cnt_next;
  logic          w_unused_regs;

  issue_bundle_t r_ent [2];
  logic [1:0]    r_cnt;
  logic          r_in_ready;

  // Register specifiers are resolved upstream; only the values arrive here.
  assign w_unused_regs = ^i_instr[25:16];

  alu_ctrl_decode #(.EN_SHIFT(EN_SHIFT)) u_decode (
    .i_opcode  (i_instr[31:26]),
    .i_funct   (i_instr[5:0]),
    .o_unit    (w_unit),
    .o_op      (w_op),
    .o_a_sel   (w_a_sel),
    .o_b_sel   (w_b_sel),
    .o_illegal (w_illegal)
  );

  // Operand A source mux.
  always_comb begin
    w_a = '0;
    case (w_a_sel)
      ASEL_RS: w_a = i_rs_val;
      ASEL_RT: w_a = i_rt_val;
      default: w_a = '0;
    endcase
  end

  // Operand B source mux, including immediate extension and LUI placement.
  always_comb begin
    w_b = '0;
    case (w_b_sel)
      BSEL_RT:    w_b = i_rt_val;
      BSEL_ZIMM:  w_b = DATA_W'(i_instr[15:0]);
      BSEL_SIMM:  w_b = DATA_W'($signed(i_instr[15:0]));
      BSEL_SHAMT: w_b = DATA_W'(i_instr[10:6]);
      BSEL_LUI:   w_b = DATA_W'({i_instr[15:0], 16'h0000});
      default:    w_b = '0;
    endcase
  end

  // Assemble the bundle that gets written into the buffer on accept.
  always_comb begin
    w_new         = '0;
    w_new.a       = ALU_DATA_W'(w_a);
    w_new.b       = ALU_DATA_W'(w_b);
    w_new.unit    = w_unit;
    w_new.op      = w_op;
    w_new.illegal = w_illegal;
  end

  assign o_out_valid = (r_cnt != 2'd0);
  assign o_in_ready  = r_in_ready;
  assign w_push      = i_in_valid & r_in_ready;
  assign w_pop       = o_out_valid & i_out_ready;

  // Occupancy update; push and pop together leave the count unchanged.
  always_comb begin
    w_cnt_next = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_next = r_cnt + 2'd1;
      2'b01:   w_cnt_next = r_cnt - 2'd1;
      default: w_cnt_next = r_cnt;
    endcase
  end

  // Buffer storage and registered ready; entry 0 is always the head.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ent[0]   <= '0;
      r_ent[1]   <= '0;
      r_cnt      <= 2'd0;
      r_in_ready <= 1'b1;
    end else if (i_flush) begin
      r_cnt      <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      r_cnt      <= w_cnt_next;
      r_in_ready <= (w_cnt_next < 2'd2);
      if (w_pop) begin
        // Push alongside pop only happens with one entry (ready was low when full).
        r_ent[0] <= (w_push && r_cnt == 2'd1) ? w_new : r_ent[1];
      end else if (w_push) begin
        if (r_cnt == 2'd0) r_ent[0] <= w_new;
        else               r_ent[1] <= w_new;
      end
    end
  end

  assign o_alu_a    = DATA_W'(r_ent[0].a);
  assign o_alu_b    = DATA_W'(r_ent[0].b);
  assign o_alu_unit = r_ent[0].unit;
  assign o_alu_op   = r_ent[0].op;
  assign o_illegal  = r_ent[0].illegal;

endmodule
